// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction fetch buffer between the pc stage and decode.
// Issues word reads on a req/gnt/rvalid memory port, records the address of
// each granted request, pairs returning data with that address, and queues
// the pair in a small in-order FIFO that decode drains via valid/ready.
// A flush empties the FIFO and arranges for in-flight responses to be dropped.
module ifetch_buf #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    RUN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] disc_q, disc_d;

  logic [PW-1:0] aq_wr_q, aq_wr_d;
  logic [PW-1:0] aq_rd_q, aq_rd_d;
  logic [PW-1:0] f_wr_q, f_wr_d;
  logic [PW-1:0] f_rd_q, f_rd_d;

  logic [31:0] aq_mem_q   [FIFO_DEPTH];
  logic [31:0] f_addr_q   [FIFO_DEPTH];
  logic [31:0] f_data_q   [FIFO_DEPTH];

  logic        req;
  logic        grant;
  logic        keep;
  logic        pop;
  logic        aq_push;
  logic        f_push;
  logic [CW:0] used;

  // Credit counts registered occupancy only, so a pop frees credit one cycle later.
  assign used = {1'b0, outst_q} + {1'b0, cnt_q};

  // Next-state, counter and pointer logic for both RUN and DRAIN behaviour.
  always_comb begin
    state_d = state_q;
    outst_d = outst_q;
    cnt_d   = cnt_q;
    disc_d  = disc_q;
    aq_wr_d = aq_wr_q;
    aq_rd_d = aq_rd_q;
    f_wr_d  = f_wr_q;
    f_rd_d  = f_rd_q;
    req     = 1'b0;
    grant   = 1'b0;
    keep    = 1'b0;
    pop     = 1'b0;
    aq_push = 1'b0;
    f_push  = 1'b0;
    case (state_q)
      RUN: begin
        req = rst_n & pc_valid_i & ~flush_i & (used < DEPTH_W);
        if (flush_i) begin
          cnt_d   = '0;
          outst_d = '0;
          aq_wr_d = '0;
          aq_rd_d = '0;
          f_wr_d  = '0;
          f_rd_d  = '0;
          if (imem_rvalid_i && (outst_q != '0)) begin
            disc_d = outst_q - CW'(1);
          end else begin
            disc_d = outst_q;
          end
          state_d = (disc_d != '0) ? DRAIN : RUN;
        end else begin
          grant   = req & imem_gnt_i;
          keep    = imem_rvalid_i & (outst_q != '0);
          pop     = (cnt_q != '0) & inst_ready_i;
          aq_push = grant;
          f_push  = keep;
          outst_d = outst_q + CW'(grant) - CW'(keep);
          cnt_d   = cnt_q + CW'(keep) - CW'(pop);
          if (grant) aq_wr_d = aq_wr_q + PW'(1);
          if (keep) begin
            aq_rd_d = aq_rd_q + PW'(1);
            f_wr_d  = f_wr_q + PW'(1);
          end
          if (pop) f_rd_d = f_rd_q + PW'(1);
        end
      end
      DRAIN: begin
        if (imem_rvalid_i && (disc_q != '0)) begin
          disc_d = disc_q - CW'(1);
          if (disc_q == CW'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, counters and pointers; reset discards everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      outst_q <= '0;
      cnt_q   <= '0;
      disc_q  <= '0;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      f_wr_q  <= '0;
      f_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      disc_q  <= disc_d;
      aq_wr_q <= aq_wr_d;
      aq_rd_q <= aq_rd_d;
      f_wr_q  <= f_wr_d;
      f_rd_q  <= f_rd_d;
    end
  end

  // Storage for request addresses and fetched {addr, data} pairs; validity comes from the counters.
  always_ff @(posedge clk) begin
    if (aq_push) aq_mem_q[aq_wr_q] <= pc_i;
    if (f_push) begin
      f_addr_q[f_wr_q] <= aq_mem_q[aq_rd_q];
      f_data_q[f_wr_q] <= imem_rdata_i;
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = pc_i;
  assign pc_ready_o   = req & imem_gnt_i;
  assign inst_valid_o = (cnt_q != '0);
  assign inst_o       = inst_valid_o ? f_data_q[f_rd_q] : 32'h0;
  assign inst_addr_o  = inst_valid_o ? f_addr_q[f_rd_q] : 32'h0;

endmodule
